// File: rtl/add_arbiter_if.sv
// Bundles both requester operand/handshake channels and the shared result
// channel of add_arbiter; master is the requester/consumer side.
interface add_arbiter_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic             valid0;
  logic             ready0;

  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
  logic             valid1;
  logic             ready1;

  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             rid;
  logic             rvalid;
  logic             rready;
  logic [7:0]       opcnt;

  modport master (
    output a0, b0, cin0, valid0,
    output a1, b1, cin1, valid1,
    output rready,
    input  ready0, ready1,
    input  sum, cout, rid, rvalid, opcnt
  );

  modport slave (
    input  a0, b0, cin0, valid0,
    input  a1, b1, cin1, valid1,
    input  rready,
    output ready0, ready1,
    output sum, cout, rid, rvalid, opcnt
  );
endinterface

// File: rtl/add_arbiter.sv
// Two requesters share one WIDTH-bit ripple-carry adder through a round-robin
// grant; each accepted request yields one registered result held until retired.
module add_arbiter #(
  parameter int WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  add_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             rid_q, rid_d;
  logic             rvalid_q, rvalid_d;
  logic [7:0]       opcnt_q, opcnt_d;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH:0]   carry;

  // A lone requester always wins; on contention prio_q picks the winner.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (bus.valid0 && (!bus.valid1 || !prio_q)) begin
        grant0 = 1'b1;
      end else if (bus.valid1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign sel        = grant1;
  assign bus.ready0 = grant0;
  assign bus.ready1 = grant1;

  always_comb begin
    op_a     = sel ? bus.a1 : bus.a0;
    op_b     = sel ? bus.b1 : bus.b0;
    op_cin   = sel ? bus.cin1 : bus.cin0;
    add_sum  = '0;
    carry    = '0;
    carry[0] = op_cin;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i]   = op_a[i] ^ op_b[i] ^ carry[i];
      carry[i+1]   = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
  end

  // Retiring always returns to IDLE first, so accept and retire never share an edge.
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    rid_d    = rid_q;
    rvalid_d = rvalid_q;
    opcnt_d  = opcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = HOLD;
          prio_d   = ~sel;
          sum_d    = add_sum;
          cout_d   = carry[WIDTH];
          rid_d    = sel;
          rvalid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          opcnt_d  = opcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      rid_q    <= 1'b0;
      rvalid_q <= 1'b0;
      opcnt_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      rid_q    <= rid_d;
      rvalid_q <= rvalid_d;
      opcnt_q  <= opcnt_d;
    end
  end

  assign bus.sum    = sum_q;
  assign bus.cout   = cout_q;
  assign bus.rid    = rid_q;
  assign bus.rvalid = rvalid_q;
  assign bus.opcnt  = opcnt_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, operand/sum width in bits; the datapath is a ripple chain of WIDTH full adders.
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports a0, b0  input  WIDTH each  requester-0 operands.
REQ-005 The block SHALL have port cin0  input  1  requester-0 carry-in.
REQ-006 The block SHALL have port valid0  input  1  requester-0 holds a request.
REQ-007 The block SHALL have port ready0  output  1  requester-0 request accepted this cycle.
REQ-008 The block SHALL have ports a1, b1, cin1, valid1, ready1, identical to REQ-004..REQ-007, for requester 1.
REQ-009 The block SHALL have port sum  output  WIDTH  registered sum of the granted operation.
REQ-010 The block SHALL have port cout  output  1  registered carry-out of the granted operation.
REQ-011 The block SHALL have port rid  output  1  index of the requester owning sum/cout.
REQ-012 The block SHALL have port rvalid  output  1  result valid.
REQ-013 The block SHALL have port rready  input  1  consumer accepts the result.
REQ-014 The block SHALL have port opcnt  output  8  count of completed results, modulo 256.

Function
REQ-015 The block SHALL share one WIDTH-bit ripple adder between the two requesters: sum + cout*2^WIDTH = a + b + cin of the granted requester, exactly.
REQ-016 The FSM SHALL have two states, IDLE and HOLD.
REQ-017 In IDLE, ready0/ready1 SHALL be combinational; at most one is high; the request is accepted on an edge where validN and readyN are both high.
REQ-018 With only validN high in IDLE, readyN SHALL be 1.
REQ-019 With both valid in IDLE, readyN SHALL be 1 for N = prio, a 1-bit round-robin pointer.
REQ-020 On accept of requester N, prio SHALL become 1-N, whatever its previous value.
REQ-021 On accept, the block SHALL register sum, cout, rid=N and rvalid=1, and SHALL move to HOLD; latency is one cycle from accept edge to rvalid.
REQ-022 In HOLD, ready0 and ready1 SHALL be 0; sum, cout and rid SHALL stay stable while rvalid=1 and rready=0.
REQ-023 In HOLD with rready=1, on that edge rvalid SHALL clear, opcnt SHALL increment (255 wraps to 0) and the FSM SHALL return to IDLE.
REQ-024 No new request SHALL be accepted in the same cycle a result is retired; maximum throughput is one result per two cycles.
REQ-025 Operands SHALL be sampled only on the accept edge; later operand changes SHALL not affect the held result.
REQ-026 Requests dropped before acceptance (valid deasserted) SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, rvalid=0, sum=0, cout=0, rid=0, opcnt=0 and prio=0, independent of clk.
REQ-028 Reset asserted in HOLD SHALL discard the pending result without incrementing opcnt.
REQ-029 After rst_n rises, the first accept SHALL occur no earlier than the first rising clk edge.

Verification
REQ-030 Single op: valid0=1, a0=3'b101, b0=3'b011, cin0=1, rready=1 -> ready0=1 in IDLE, next cycle rvalid=1, sum=3'b001, cout=1, rid=0, then opcnt=1.
REQ-031 Contention: valid0=valid1=1 held continuously after reset, rready=1 -> grants alternate 0,1,0,1; rid sequence 0,1,0,1; one result every two cycles.
REQ-032 Backpressure: rready=0 for 5 cycles after accept -> rvalid, sum, cout and rid stay constant; ready0=ready1=0; opcnt unchanged; retire on the first rready=1 edge.
REQ-033 Max operands: a1=b1=3'b111, cin1=1 -> sum=3'b111, cout=1; zero operands with cin=0 -> sum=0, cout=0.
REQ-034 Reset mid-HOLD: pull rst_n low while rvalid=1 -> rvalid=0, opcnt=0 and prio=0 asynchronously; with both requesters valid after release, requester 0 wins.
REQ-035 Wrap: 256 completed ops -> opcnt returns to 0.
